// File: rtl/fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
// The FIFO_ALMOST_EN macro (see fifo_ctrl) adds almost_full/almost_empty flags.
package fifo_pkg;

  localparam int FIFO_ADDR_W    = 4;
  localparam int FIFO_ALMOST_TH = 2;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int FIFO_DEPTH = fifo_depth(FIFO_ADDR_W);

  typedef logic [FIFO_ADDR_W-1:0] ptr_t;
  typedef logic [FIFO_ADDR_W:0]   count_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register; rolls over from 2**W-1 to 0 naturally.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Address/enable sequencer and occupancy flags for a RAM-backed synchronous FIFO.
// Define FIFO_ALMOST_EN to add the almost_full/almost_empty outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int ALMOST_TH = FIFO_ALMOST_TH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int              DEPTH     = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

  logic wr_acc;
  logic rd_acc;

  // A request is accepted in the cycle it is asserted if the FIFO can take it
  // (not full for writes, not empty for reads) and rst is low; there is no
  // back-pressure handshake, rejected requests are simply dropped and flagged.
  assign wr_acc = wr_req & ~full & ~rst;
  assign rd_acc = rd_req & ~empty & ~rst;
  assign ram_we = wr_acc;
  assign ram_re = rd_acc;

  fifo_ptr #(.W(ADDR_W)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (ram_waddr)
  );

  fifo_ptr #(.W(ADDR_W)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (ram_raddr)
  );

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // Registered-read RAM: data for this cycle's read appears next cycle.
      rd_valid  <= rd_acc;
      overflow  <= overflow | (wr_req & full);
      underflow <= underflow | (rd_req & empty);
    end
  end

`ifdef FIFO_ALMOST_EN
  localparam int              AF_INT = DEPTH - ALMOST_TH;
  localparam int              AE_INT = ALMOST_TH;
  localparam logic [ADDR_W:0] AF_TH  = AF_INT[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_TH  = AE_INT[ADDR_W:0];

  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl at ADDR_W=2 (DEPTH=4), ALMOST_TH=1.
module tb_fifo_ctrl;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req;
  logic         rd_req;
  logic         ram_we;
  logic [W-1:0] ram_waddr;
  logic         ram_re;
  logic [W-1:0] ram_raddr;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;
`ifdef FIFO_ALMOST_EN
  logic         almost_full;
  logic         almost_empty;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: address of every accepted write, in order; reads must match.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_wptr;

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_W(W), .ALMOST_TH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  task automatic drive(input logic r, input logic w, input logic rd);
    @(negedge clk);
    rst    = r;
    wr_req = w;
    rd_req = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (ram_we !== 1'b1 || ram_waddr !== model_wptr) begin
        n_errors++;
        $display("FAIL push: we=%b waddr=%0d, expected we=1 waddr=%0d", ram_we, ram_waddr, model_wptr);
      end
      exp_q.push_back(model_wptr);
      model_wptr = model_wptr + 1'b1;
      tick();
    end
  endtask

  task automatic pop_n(input int n);
    logic [W-1:0] exp_a;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (ram_re !== 1'b1 || ram_raddr !== exp_a) begin
        n_errors++;
        $display("FAIL pop: re=%b raddr=%0d, expected re=1 raddr=%0d", ram_re, ram_raddr, exp_a);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL pop_rd_valid: got %b expected 1", rd_valid);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({empty, full, count, rd_valid, overflow, underflow} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d rd_valid=%b ovf=%b unf=%b, expected 1 0 0 0 0 0",
               empty, full, count, rd_valid, overflow, underflow);
    end
    exp_q.delete();
    model_wptr = '0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (ram_we !== 1'b1 || ram_waddr !== W'(i)) begin
        n_errors++;
        $display("FAIL fill_addr: we=%b waddr=%0d, expected we=1 waddr=%0d", ram_we, ram_waddr, i);
      end
      exp_q.push_back(W'(i));
      model_wptr = model_wptr + 1'b1;
      tick();
    end
    n_checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_full: full=%b count=%0d ovf=%b, expected 1 4 0", full, count, overflow);
    end
    drive(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ram_we !== 1'b0) begin
      n_errors++;
      $display("FAIL overflow_we: got %b expected 0", ram_we);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      n_errors++;
      $display("FAIL overflow_flag: ovf=%b count=%0d, expected 1 4", overflow, count);
    end
  endtask

  task automatic test_drain_underflow();
    pop_n(4);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (empty !== 1'b1 || count !== 3'd0 || rd_valid !== 1'b0 || underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_empty: empty=%b count=%0d rd_valid=%b unf=%b, expected 1 0 0 0",
               empty, count, rd_valid, underflow);
    end
    drive(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ram_re !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_re: got %b expected 0", ram_re);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 3'd0) begin
      n_errors++;
      $display("FAIL underflow_flag: unf=%b rd_valid=%b count=%0d, expected 1 0 0", underflow, rd_valid, count);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] waddr_seq [6];
    waddr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      if (i == 3) pop_n(3);
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (ram_we !== 1'b1 || ram_waddr !== waddr_seq[i]) begin
        n_errors++;
        $display("FAIL wrap_addr[%0d]: we=%b waddr=%0d, expected we=1 waddr=%0d", i, ram_we, ram_waddr, waddr_seq[i]);
      end
      exp_q.push_back(waddr_seq[i]);
      model_wptr = model_wptr + 1'b1;
      tick();
    end
    n_checks++;
    if (count !== 3'd3) begin
      n_errors++;
      $display("FAIL wrap_count: got %0d expected 3", count);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] exp_a;
    // count 3 -> 2, then wr+rd together
    pop_n(1);
    drive(1'b0, 1'b1, 1'b1);
    exp_a = exp_q.pop_front();
    n_checks++;
    if (ram_we !== 1'b1 || ram_re !== 1'b1 || ram_raddr !== exp_a || ram_waddr !== model_wptr) begin
      n_errors++;
      $display("FAIL sim_mid_en: we=%b re=%b raddr=%0d waddr=%0d, expected 1 1 %0d %0d",
               ram_we, ram_re, ram_raddr, ram_waddr, exp_a, model_wptr);
    end
    exp_q.push_back(model_wptr);
    model_wptr = model_wptr + 1'b1;
    tick();
    n_checks++;
    if (count !== 3'd2) begin
      n_errors++;
      $display("FAIL sim_mid_count: got %0d expected 2", count);
    end
    // drain to empty, then wr+rd: only the write lands
    pop_n(2);
    drive(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ram_we !== 1'b1 || ram_re !== 1'b0) begin
      n_errors++;
      $display("FAIL sim_empty_en: we=%b re=%b, expected 1 0", ram_we, ram_re);
    end
    exp_q.push_back(model_wptr);
    model_wptr = model_wptr + 1'b1;
    tick();
    n_checks++;
    if (count !== 3'd1) begin
      n_errors++;
      $display("FAIL sim_empty_count: got %0d expected 1", count);
    end
    // fill to full, then wr+rd: only the read lands
    push_n(3);
    drive(1'b0, 1'b1, 1'b1);
    exp_a = exp_q.pop_front();
    n_checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b1 || ram_raddr !== exp_a) begin
      n_errors++;
      $display("FAIL sim_full_en: we=%b re=%b raddr=%0d, expected 0 1 %0d", ram_we, ram_re, ram_raddr, exp_a);
    end
    tick();
    n_checks++;
    if (count !== 3'd3 || rd_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL sim_full_count: count=%0d rd_valid=%b, expected 3 1", count, rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_en: we=%b re=%b, expected 0 0", ram_we, ram_re);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({count, ram_waddr, ram_raddr, overflow, underflow, rd_valid, empty} !==
        {3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL rst_mid_state: count=%0d waddr=%0d raddr=%0d ovf=%b unf=%b rdv=%b empty=%b, expected 0 0 0 0 0 0 1",
               count, ram_waddr, ram_raddr, overflow, underflow, rd_valid, empty);
    end
    exp_q.delete();
    model_wptr = '0;
    push_n(1);
    pop_n(1);
  endtask

`ifdef FIFO_ALMOST_EN
  task automatic test_almost();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (almost_empty !== 1'b1 || almost_full !== 1'b0 || count !== 3'd0) begin
      n_errors++;
      $display("FAIL almost_c0: ae=%b af=%b count=%0d, expected 1 0 0", almost_empty, almost_full, count);
    end
    push_n(2);
    n_checks++;
    if (almost_empty !== 1'b0 || almost_full !== 1'b0) begin
      n_errors++;
      $display("FAIL almost_c2: ae=%b af=%b, expected 0 0", almost_empty, almost_full);
    end
    push_n(1);
    n_checks++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
      n_errors++;
      $display("FAIL almost_c3: ae=%b af=%b, expected 0 1", almost_empty, almost_full);
    end
    pop_n(3);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    model_wptr = '0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
`ifdef FIFO_ALMOST_EN
    test_almost();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_residue: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
